// File: rtl/button_conditioner_pkg.sv
// Shared types and sizing helpers for the push-button conditioner.
package button_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD_DELAY   = 3'd2,
    HELD_REPEAT  = 3'd3,
    RELEASE_WAIT = 3'd4
  } btn_state_t;

  // One shared counter must reach max-1 of the three cycle parameters.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects one push button, with optional
// auto-repeat; down_pulse feeds the downstream button counter.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC   = 250000,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DLY_CYC = 50000000,
  parameter int REPEAT_CYC     = 10000000,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,  // "release" is a reserved word
  output logic rpt,
  output logic down_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, REPEAT_DLY_CYC, REPEAT_CYC);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY_CYC - 1);
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic btn_pol, s;
  btn_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic level_nx, press_nx, release_nx, rpt_nx;

  assign btn_pol = btn_in ^ (ACTIVE_LOW != 0);

  bit_sync #(.STAGES(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_pol),
    .q     (s)
  );

  // A change on s always takes priority over a counter boundary.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    level_nx   = level;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    rpt_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx = HELD_DELAY;
          cnt_nx   = '0;
          press_nx = 1'b1;
          level_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD_DELAY: begin
        if (!s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end else if (REPEAT_EN != 0 && cnt == DLY_LAST) begin
          state_nx = HELD_REPEAT;
          cnt_nx   = '0;
          rpt_nx   = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (!s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end else if (cnt == RPT_LAST) begin
          cnt_nx = '0;
          rpt_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nx = HELD_DELAY;
          cnt_nx   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nx   = IDLE;
          cnt_nx     = '0;
          release_nx = 1'b1;
          level_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        level_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      rpt           <= 1'b0;
      down_pulse    <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      level         <= level_nx;
      press         <= press_nx;
      release_pulse <= release_nx;
      rpt           <= rpt_nx;
      down_pulse    <= press_nx | rpt_nx;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulses (kind + cycle) are queued when the pin is
// driven and matched against the pulses each conditioner emits.
module tb_button_conditioner;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  localparam logic [2:0] K_PRESS = 3'b001;
  localparam logic [2:0] K_REL   = 3'b010;
  localparam logic [2:0] K_RPT   = 3'b100;
  localparam int LAT = 7;  // drive at negedge c -> sampled at c+1 -> pulse after edge c+1+4+2

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] btn = 2'b10;
  logic [1:0] level, press, rel, rpt, down;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int down_cnt [2];
  ev_t exp_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_conditioner #(
    .DEBOUNCE_CYC(4), .REPEAT_EN(1), .REPEAT_DLY_CYC(20), .REPEAT_CYC(8), .ACTIVE_LOW(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .btn_in(btn[0]), .level(level[0]), .press(press[0]),
    .release_pulse(rel[0]), .rpt(rpt[0]), .down_pulse(down[0])
  );

  button_conditioner #(
    .DEBOUNCE_CYC(4), .REPEAT_EN(1), .REPEAT_DLY_CYC(20), .REPEAT_CYC(8), .ACTIVE_LOW(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .btn_in(btn[1]), .level(level[1]), .press(press[1]),
    .release_pulse(rel[1]), .rpt(rpt[1]), .down_pulse(down[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic push_ev(input int i, input int c, input logic [2:0] k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q[i].push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic mon(input int i, input logic p, input logic r, input logic t, input logic d);
    logic [2:0] k;
    ev_t e;
    k = {t, r, p};
    if (d) down_cnt[i]++;
    if (k != 3'b000) begin
      if (exp_q[i].size() == 0) begin
        chk($sformatf("unexpected_pulse%0d", i), 32'(k), 32'd0);
      end else begin
        e = exp_q[i].pop_front();
        chk($sformatf("kind%0d", i), 32'(k), 32'(e.kind));
        chk($sformatf("cycle%0d", i), cyc, e.cyc);
        chk($sformatf("down_with_pulse%0d", i), 32'(d), 32'(e.kind[0] | e.kind[2]));
      end
    end else if (d) begin
      chk($sformatf("down_alone%0d", i), 32'(d), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, press[0], rel[0], rpt[0], down[0]);
    mon(1, press[1], rel[1], rpt[1], down[1]);
  end

  initial begin
    int p;
    down_cnt[0] = 0;
    down_cnt[1] = 0;

    // reset state
    at(2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_level%0d", i), 32'(level[i]), 0);
      chk($sformatf("rst_press%0d", i), 32'(press[i]), 0);
      chk($sformatf("rst_release%0d", i), 32'(rel[i]), 0);
      chk($sformatf("rst_rpt%0d", i), 32'(rpt[i]), 0);
      chk($sformatf("rst_down%0d", i), 32'(down[i]), 0);
    end
    at(3);
    reset = 1'b0;

    // active-low pin held high: nothing happens
    at(10);
    chk("idle_level1", 32'(level[1]), 0);
    chk("idle_down1", down_cnt[1], 0);

    // clean press for 10 cycles on both polarities
    btn = 2'b01;
    push_ev(0, 10 + LAT, K_PRESS);
    push_ev(1, 10 + LAT, K_PRESS);
    at(20);
    chk("held_level0", 32'(level[0]), 1);
    chk("held_level1", 32'(level[1]), 1);
    btn = 2'b10;
    push_ev(0, 20 + LAT, K_REL);
    push_ev(1, 20 + LAT, K_REL);
    at(26);
    chk("pre_release_level0", 32'(level[0]), 1);
    at(35);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("clean_level%0d", i), 32'(level[i]), 0);
      chk($sformatf("clean_pending%0d", i), exp_q[i].size(), 0);
      chk($sformatf("clean_downs%0d", i), down_cnt[i], 1);
    end

    // bounce: 1,0,1,0 each for 2 cycles
    at(40); btn[0] = 1'b1;
    at(42); btn[0] = 1'b0;
    at(44); btn[0] = 1'b1;
    at(46); btn[0] = 1'b0;
    at(66);
    chk("bounce_level", 32'(level[0]), 0);
    chk("bounce_pending", exp_q[0].size(), 0);
    chk("bounce_downs", down_cnt[0], 1);

    // long hold with auto-repeat
    at(70);
    btn[0] = 1'b1;
    p = 70 + LAT;
    push_ev(0, p, K_PRESS);
    for (int k = 0; k < 5; k++) push_ev(0, p + 20 + 8 * k, K_RPT);

    // 2-cycle release glitch after the last repeat: repeat delay restarts
    at(p + 53);
    btn[0] = 1'b0;
    at(p + 55);
    btn[0] = 1'b1;
    for (int k = 0; k < 3; k++) push_ev(0, (p + 55) + 3 + 20 + 8 * k, K_RPT);
    at(p + 57);
    chk("hold_downs", down_cnt[0], 1 + 6);
    at(p + 60);
    chk("glitch_level", 32'(level[0]), 1);

    // async reset while repeating
    at(175);
    chk("pre_reset_level", 32'(level[0]), 1);
    chk("pre_reset_pending", exp_q[0].size(), 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_level", 32'(level[0]), 0);
    chk("arst_press", 32'(press[0]), 0);
    chk("arst_release", 32'(rel[0]), 0);
    chk("arst_rpt", 32'(rpt[0]), 0);
    chk("arst_down", 32'(down[0]), 0);
    at(177);
    reset = 1'b0;
    push_ev(0, 177 + LAT, K_PRESS);
    at(190);
    chk("re_press_level", 32'(level[0]), 1);
    btn[0] = 1'b0;
    push_ev(0, 190 + LAT, K_REL);

    at(205);
    chk("final_level0", 32'(level[0]), 0);
    chk("final_pending0", exp_q[0].size(), 0);
    chk("final_pending1", exp_q[1].size(), 0);
    chk("final_downs0", down_cnt[0], 1 + 6 + 3 + 1);
    chk("final_downs1", down_cnt[1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
